// File: rtl/mem2p_rd_stream_if.sv
// Valid/ready word stream carrying a last-word tag.
// Master drives valid/data/last; slave drives ready.
interface mem2p_rd_stream_if #(
    parameter int WIDTH = 24
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/mem2p_rd_stream.sv
// Streams a wrap-around address range out of a simple dual-port memory's read port
// through a 2-entry skid buffer onto a valid/ready stream.
module mem2p_rd_stream #(
    parameter  int DEPTH = 2048,
    parameter  int WIDTH = 24,
    localparam int A     = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A-1:0]       base_addr,
    input  logic [A:0]         len,
    output logic               busy,
    output logic               done,
    output logic [A-1:0]       mem_addrr,
    output logic               mem_mer,
    input  logic [WIDTH-1:0]   mem_dout,
    mem2p_rd_stream_if.master  m
);
    localparam logic [A-1:0] LAST_ADDR = A'(DEPTH - 1);
    localparam logic [A:0]   DEPTH_LEN = (A+1)'(DEPTH);
    localparam logic [A:0]   ONE_LEN   = (A+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state_q, state_d;

    logic [A-1:0]            addr_q;
    logic [A-1:0]            hold_q;
    logic [A:0]              remain_q;
    logic                    vld_p1;
    logic                    last_p1;
    logic [1:0][WIDTH-1:0]   buf_data;
    logic [1:0]              buf_last;
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              count_q;
    logic                    done_q;

    logic                    pop;
    logic                    rd_en;
    logic                    go;
    logic [2:0]              occ;
    logic [A:0]              len_clamped;

    // Occupancy the buffer will have once the in-flight read lands; a new read
    // is only safe while that leaves room for one more word.
    assign pop         = (count_q != 2'd0) && m.ready;
    assign occ         = 3'(count_q) + 3'(vld_p1) - 3'(pop);
    assign rd_en       = (state_q == RUN) && (remain_q != '0) && (occ <= 3'd1);
    assign go          = (state_q == IDLE) && start;
    assign len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;

    assign mem_mer   = rd_en;
    assign mem_addrr = rd_en ? addr_q : hold_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign m.valid   = (count_q != 2'd0);
    assign m.data    = buf_data[rd_ptr];
    assign m.last    = buf_last[rd_ptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (len != '0)) state_d = RUN;
            RUN:     if (rd_en && (remain_q == ONE_LEN)) state_d = FLUSH;
            FLUSH:   if (pop && m.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            hold_q   <= '0;
            remain_q <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            buf_data <= '0;
            buf_last <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count_q  <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go && (len != '0)) begin
                addr_q   <= base_addr;
                remain_q <= len_clamped;
            end else if (rd_en) begin
                addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + A'(1);
                remain_q <= remain_q - ONE_LEN;
                hold_q   <= addr_q;
            end
            // p1: memory returns the word read in the previous cycle
            vld_p1  <= rd_en;
            last_p1 <= rd_en && (remain_q == ONE_LEN);
            if (vld_p1) begin
                buf_data[wr_ptr] <= mem_dout;
                buf_last[wr_ptr] <= last_p1;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count_q <= count_q + 2'(vld_p1) - 2'(pop);
            done_q  <= (go && (len == '0)) || ((state_q == FLUSH) && pop && m.last);
        end
    end
endmodule

// File: tb/tb_mem2p_rd_stream.sv
// Bench for mem2p_rd_stream: table of transfers checked against a beat/address
// scoreboard, plus hand sequences for mid-transfer reset.
module tb_mem2p_rd_stream;
    localparam int DEPTH = 16;
    localparam int WIDTH = 24;
    localparam int A     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [A-1:0]     base_addr;
    logic [A:0]       len;
    logic             busy;
    logic             done;
    logic [A-1:0]     mem_addrr;
    logic             mem_mer;
    logic [WIDTH-1:0] mem_dout = '0;

    always #5 clk = ~clk;

    mem2p_rd_stream_if #(.WIDTH(WIDTH)) s ();

    mem2p_rd_stream #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_addrr (mem_addrr),
        .mem_mer   (mem_mer),
        .mem_dout  (mem_dout),
        .m         (s)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(32'h100 + i);
    always @(posedge clk) if (mem_mer) mem_dout <= mem[mem_addrr];

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    typedef struct {
        int base;
        int len;
        int rmode;    // 0: ready high, 1: 1,0,0,1 pattern, 2: random
        int inject;   // extra start pulses while busy
        int exp_n;
        int exp_done; // cycle of done relative to start, -1 = not fixed
    } vec_t;

    beat_t            exp_q[$];
    logic [A-1:0]     addr_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, xfer_start = 0, rmode = 0;
    int mers = 0, beats = 0, dones = 0;
    int rd_issued = 0, accepted = 0;
    int first_vld = -1, done_cyc = -1;
    logic busy_at_done = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        beat_t e;
        logic  pop;
        @(negedge clk);
        pop = s.valid && s.ready;
        if (mem_mer) begin
            mers++;
            if (addr_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else check("read_addr", 32'(mem_addrr), 32'(addr_q.pop_front()));
        end
        check("buffered_le2", 32'(rd_issued - accepted <= 2), 32'd1);
        if (prev_stall) begin
            check("stall_valid", 32'(s.valid), 32'd1);
            check("stall_data", 32'(s.data), 32'(prev_data));
            check("stall_last", 32'(s.last), 32'(prev_last));
        end
        if (s.valid && first_vld < 0) first_vld = cyc;
        if (pop) begin
            beats++;
            if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(s.data), 32'(e.data));
                check("beat_last", 32'(s.last), 32'(e.last));
            end
        end
        if (done) dones++;
        if (done && cyc > xfer_start && done_cyc < 0) begin
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        prev_stall = s.valid && !s.ready;
        prev_data  = s.data;
        prev_last  = s.last;
        rd_issued += int'(mem_mer);
        accepted  += int'(pop);
        cyc++;
        @(posedge clk);
        #1;
        case (rmode)
            0:       s.ready = 1'b1;
            1:       s.ready = ((cyc - xfer_start) % 4 == 0) || ((cyc - xfer_start) % 4 == 3);
            default: s.ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(s.valid), 32'd0);
        check({tag, "_last"}, 32'(s.last), 32'd0);
        check({tag, "_data"}, 32'(s.data), 32'd0);
        check({tag, "_mer"}, 32'(mem_mer), 32'd0);
        check({tag, "_addr"}, 32'(mem_addrr), 32'd0);
    endtask

    task automatic load_expect(input int base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = WIDTH'(32'h100 + (base + i) % DEPTH);
            b.last = (i == n - 1);
            exp_q.push_back(b);
            addr_q.push_back(A'((base + i) % DEPTH));
        end
    endtask

    task automatic run(input vec_t v);
        int st, b0, m0, n;
        n = (v.len > DEPTH) ? DEPTH : v.len;
        load_expect(v.base, n);
        rmode      = v.rmode;
        xfer_start = cyc;
        st         = cyc;
        first_vld  = -1;
        done_cyc   = -1;
        b0         = beats;
        m0         = mers;
        s.ready    = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        start      = 1'b1;
        base_addr  = A'(v.base);
        len        = (A+1)'(v.len);
        tick();
        start = 1'b0;
        check("busy_cycle1", 32'(busy), 32'(n > 0));
        for (int k = 0; k < v.inject; k++) begin
            start     = 1'b1;
            base_addr = '0;
            len       = 5'd5;
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 200 && done_cyc < 0; k++) tick();
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        if (v.exp_done >= 0) check("done_cycle", 32'(done_cyc - st), 32'(v.exp_done));
        check("beat_count", 32'(beats - b0), 32'(v.exp_n));
        check("read_count", 32'(mers - m0), 32'(v.exp_n));
        check("leftover", 32'(exp_q.size() + addr_q.size()), 32'd0);
        if (n > 0) begin
            check("first_valid_cycle", 32'(first_vld - st), 32'd3);
            check("busy_at_done", 32'(busy_at_done), 32'd0);
            check("addr_hold", 32'(mem_addrr), 32'((v.base + n - 1) % DEPTH));
        end else begin
            check("no_valid", 32'(first_vld), 32'hFFFF_FFFF);
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    vec_t vecs[$];

    initial begin
        int d0, b0;
        vecs.push_back('{3, 1, 0, 0, 1, 4});
        vecs.push_back('{0, 8, 0, 0, 8, 11});
        vecs.push_back('{0, 8, 1, 0, 8, -1});
        vecs.push_back('{14, 4, 0, 0, 4, 7});
        vecs.push_back('{0, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 20, 0, 0, 16, 19});
        vecs.push_back('{2, 6, 0, 3, 6, 9});
        vecs.push_back('{5, 16, 2, 0, 16, -1});
        vecs.push_back('{9, 3, 0, 0, 3, 6});

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        s.ready   = 1'b1;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run(vecs[i]);
            tick();
        end

        // Reset in the cycle after the second beat of a len=8 transfer.
        load_expect(0, 8);
        rmode      = 0;
        xfer_start = cyc;
        s.ready    = 1'b1;
        start      = 1'b1;
        base_addr  = '0;
        len        = 5'd8;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        d0  = dones;
        tick();
        check_reset_vals("midreset");
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        rd_issued  = 0;
        accepted   = 0;
        prev_stall = 1'b0;
        b0         = beats;
        repeat (4) tick();
        check("midreset_no_done", 32'(dones - d0), 32'd0);
        check("midreset_no_beats", 32'(beats - b0), 32'd0);
        run('{5, 2, 0, 0, 2, 5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
